uart_rx_param: RTL

//  Parametrised oversampling UART receiver: next-generation RX for the custom UART.

---
 rtl/uart_rx_param_pkg.sv | 26 ++
 rtl/uart_rx_param_sampler.sv | 72 +++++++
 rtl/uart_rx_param.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised oversampling UART receiver:
// FSM state encoding, parity mode codes, default oversampling factor
// and the 3-sample majority vote helper.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Default number of ena ticks per bit period.
  localparam int SAMPLING_FACTOR = 16;

  // Majority of three samples taken around mid-bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// Line front end: 2-FF synchronizer, oversample counter and mid-bit
// majority vote. bit_mid_o strobes on the tick of the third (last) vote
// sample with bit_val_o valid; bit_end_o strobes on the counter wrap tick.
module uart_rx_sampler
  import uart_rx_param_pkg::*;
#(
  parameter int OVERSAMPLE = SAMPLING_FACTOR
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic bit_i,
  input  logic os_clr_i,
  output logic rx_s_o,
  output logic bit_mid_o,
  output logic bit_end_o,
  output logic bit_val_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] VOTE_A  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] VOTE_B  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] VOTE_C  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);

  logic          sync1_q;
  logic          rx_s_q;
  logic          samp_a_q;
  logic          samp_b_q;
  logic [CW-1:0] os_cnt_q;

  // Two-stage synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bit_i;
      rx_s_q  <= sync1_q;
    end
  end

  // Oversample position within the bit; held at 0 while the FSM is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt_q <= '0;
    end else if (ena_i) begin
      if (os_clr_i || (os_cnt_q == OS_LAST)) begin
        os_cnt_q <= '0;
      end else begin
        os_cnt_q <= os_cnt_q + CW'(1);
      end
    end
  end

  // Capture the first two vote samples; the third is taken live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a_q <= 1'b0;
      samp_b_q <= 1'b0;
    end else if (ena_i) begin
      if (os_cnt_q == VOTE_A) samp_a_q <= rx_s_q;
      if (os_cnt_q == VOTE_B) samp_b_q <= rx_s_q;
    end
  end

  assign rx_s_o    = rx_s_q;
  assign bit_mid_o = ena_i && (os_cnt_q == VOTE_C);
  assign bit_end_o = ena_i && (os_cnt_q == OS_LAST);
  assign bit_val_o = majority3(samp_a_q, samp_b_q, rx_s_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: frame FSM, data shift register,
// parity/framing/overrun checks and the unread/rd_ack handshake.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = SAMPLING_FACTOR,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 Bit_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 bussy
);

  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY_MODE == PARITY_EVEN) || (PARITY_MODE == PARITY_ODD);
  localparam bit         ODD_PARITY = (PARITY_MODE == PARITY_ODD);

  logic rx_s;
  logic bit_mid_s;
  logic bit_end_s;
  logic bit_val_s;
  logic os_clr_s;
  logic parity_bad_s;

  rx_state_e            state_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt_q;
  logic                 par_bit_q;
  logic                 ferr_acc_q;
  logic                 unread_q;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .ena_i     (ena),
    .bit_i     (Bit_in),
    .os_clr_i  (os_clr_s),
    .rx_s_o    (rx_s),
    .bit_mid_o (bit_mid_s),
    .bit_end_o (bit_end_s),
    .bit_val_o (bit_val_s)
  );

  // The oversample counter restarts at the start-detect tick.
  assign os_clr_s = (state_q == ST_IDLE);

  // Data XOR parity bit must equal 1 for odd parity, 0 for even.
  assign parity_bad_s = HAS_PARITY && (((^shift_q) ^ par_bit_q) != ODD_PARITY);

  // Frame FSM with registered outputs; early exit at the last stop-bit vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= 4'd0;
      par_bit_q   <= 1'b0;
      ferr_acc_q  <= 1'b0;
      unread_q    <= 1'b0;
      out         <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      bussy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (rd_ack) begin
        unread_q    <= 1'b0;
        overrun_err <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (ena) begin
            if (armed_q && !rx_s) begin
              state_q    <= ST_START;
              armed_q    <= 1'b0;
              bussy      <= 1'b1;
              bit_cnt_q  <= 4'd0;
              ferr_acc_q <= 1'b0;
            end else if (rx_s) begin
              armed_q <= 1'b1;
            end
          end
        end
        ST_START: begin
          if (bit_mid_s && bit_val_s) begin
            state_q <= ST_IDLE;  // glitch: line was not really low
            bussy   <= 1'b0;
          end else if (bit_end_s) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_mid_s) shift_q <= {bit_val_s, shift_q[DATA_BITS-1:1]};
          if (bit_end_s) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= 4'd0;
              state_q   <= HAS_PARITY ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_mid_s) par_bit_q <= bit_val_s;
          if (bit_end_s) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (bit_mid_s) begin
            if (bit_cnt_q == LAST_STOP) begin
              out        <= shift_q;
              data_valid <= 1'b1;
              parity_err <= parity_bad_s;
              frame_err  <= ferr_acc_q | ~bit_val_s;
              if (unread_q && !rd_ack) overrun_err <= 1'b1;
              unread_q   <= 1'b1;
              state_q    <= ST_IDLE;
              bussy      <= 1'b0;
            end else begin
              ferr_acc_q <= ferr_acc_q | ~bit_val_s;
            end
          end else if (bit_end_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          bussy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
